// File: rtl/qsys_hex_pio_multi.sv
// qsys_hex_pio_multi: Avalon-MM output PIO for banks of seven-segment HEX digits.
// NUM_BANKS banks of four digits each (one byte per digit) are written with
// per-byte strobes.
// Define QSYS_HEX_PIO_BLINK_EN to add the blink engine, which provides
// BLINK_MASK, BLINK_PERIOD and STATUS. Without it, out_port mirrors the DATA
// registers directly.
module qsys_hex_pio_multi #(
  parameter int unsigned NUM_BANKS        = 2,
  parameter logic [31:0] RESET_PATTERN    = 32'h40404040,
  parameter logic [7:0]  BLANK_PATTERN    = 8'hFF,
  parameter logic [31:0] BLINK_PERIOD_RST = 32'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [3:0]               byteenable,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [32*NUM_BANKS-1:0]  out_port
);

  localparam int unsigned NumDigits = 4 * NUM_BANKS;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

  logic wr_en;
  assign wr_en = chipselect & ~write_n;

  logic [31:0]          data_q [NUM_BANKS];
  logic [31:0]          data_d [NUM_BANKS];
  logic [NumDigits-1:0] blank_digit;

  // Byte-merged writes into the addressed DATA bank
  always_comb begin
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      data_d[b] = data_q[b];
      if (wr_en && address == 4'(b)) begin
        data_d[b] = merge_bytes(data_q[b], writedata, byteenable);
      end
    end
  end

  // DATA register state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) data_q[b] <= RESET_PATTERN;
    end else begin
      data_q <= data_d;
    end
  end

`ifdef QSYS_HEX_PIO_BLINK_EN
  // Mask bits beyond the implemented digits are held at zero
  localparam logic [31:0] MaskValid = 32'hFFFF_FFFF >> (32 - NumDigits);
  localparam logic [31:0] CntRst    = (BLINK_PERIOD_RST == 32'd0) ? 32'd0
                                                                  : BLINK_PERIOD_RST - 32'd1;

  logic [31:0] mask_q, mask_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        period_wr;

  assign period_wr = wr_en && (address == 4'd9);

  // Mask/period writes and blink counter; a period write restarts the count
  always_comb begin
    mask_d   = mask_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (wr_en && address == 4'd8) begin
      mask_d = merge_bytes(mask_q, writedata, byteenable) & MaskValid;
    end
    if (period_wr) begin
      period_d = merge_bytes(period_q, writedata, byteenable);
      cnt_d    = (period_d == 32'd0) ? 32'd0 : period_d - 32'd1;
      phase_d  = 1'b0;
    end else if (period_q == 32'd0) begin
      cnt_d   = 32'd0;
      phase_d = 1'b0;
    end else if (cnt_q == 32'd0) begin
      cnt_d   = period_q - 32'd1;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  // Blink engine state
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q   <= 32'd0;
      period_q <= BLINK_PERIOD_RST;
      cnt_q    <= CntRst;
      phase_q  <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign blank_digit = mask_q[NumDigits-1:0] & {NumDigits{phase_q}};
`else
  assign blank_digit = '0;
`endif

  // Per-digit output: blanked digits show BLANK_PATTERN
  always_comb begin
    out_port = '0;
    for (int i = 0; i < int'(NumDigits); i++) begin
      out_port[8*i +: 8] = blank_digit[i] ? BLANK_PATTERN : data_q[i/4][8*(i%4) +: 8];
    end
  end

  // Zero-latency read mux; unselected or unmapped reads return 0
  always_comb begin
    readdata = 32'd0;
    if (chipselect) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        if (address == 4'(b)) readdata = data_q[b];
      end
`ifdef QSYS_HEX_PIO_BLINK_EN
      case (address)
        4'd8:    readdata = mask_q;
        4'd9:    readdata = period_q;
        4'd10:   readdata = {31'd0, phase_q};
        default: ;
      endcase
`endif
    end
  end

endmodule

// File: doc/qsys_hex_pio_multi.md
# qsys_hex_pio_multi

Parametrised Avalon-MM output PIO for the seven-segment HEX displays. It generalises the single 32-bit HEX3..HEX0 port to NUM_BANKS banks of four digits each, with per-byte write strobes. It adds a per-digit blink mask driven by a programmable half-period counter. It sits on the Qsys interconnect as an s1 slave and drives the HEX pins directly through `out_port`.

## Interface
- `NUM_BANKS`, default 2: number of 32-bit digit banks, 1..8; each byte is one digit (bit 7 unused by the pins).
- `RESET_PATTERN`, default 32'h40404040: per-bank reset value of every data register.
- `BLANK_PATTERN`, default 8'hFF: byte driven for a digit blanked by blink (active-low segments all off).
- `BLINK_PERIOD_RST`, default 0: reset value of the blink period register; 0 means blink disabled.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 4: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, qualified by `chipselect`.
- `byteenable` in 4: per-byte write enables.
- `writedata` in 32: write data.
- `readdata` out 32: read data, read latency 0.
- `out_port` out 32*NUM_BANKS: digit outputs; bank b is at bits [32b+31:32b].

## Operation
Register map (word offsets):
- 0..NUM_BANKS-1: DATA[b], read/write.
- 8: BLINK_MASK, read/write. Bit i blinks digit i, where digit i is out_port byte i. Bits ≥ 4*NUM_BANKS read 0 and ignore writes.
- 9: BLINK_PERIOD, read/write, 32 bits. Value is the half-period in clk cycles.
- 10: STATUS, read-only. Bit0 = blink phase; other bits read 0.
- Any other offset, including DATA offsets ≥ NUM_BANKS: reads 0, writes ignored.

Write behaviour:
- A write occurs when `chipselect && !write_n`.
- Only bytes with `byteenable[k]`=1 are updated; this applies to all RW registers.

Read behaviour:
- `readdata` is combinational from the registers and `address`.
- It is valid whenever `chipselect` is high. There is no waitrequest.

Blink engine:
- 32-bit down-counter `cnt` and a phase bit.
- When BLINK_PERIOD=0: `cnt` is held at 0 and phase is forced 0.
- Otherwise, each edge:
  - if `cnt`==0, then `cnt`←BLINK_PERIOD-1 and phase←~phase;
  - else `cnt`←`cnt`-1.
- A write to BLINK_PERIOD (any byteenable) loads `cnt`←new_value-1 (0 if new_value=0) and clears phase. This write takes priority over an expiry on the same edge.
- Output rule: out_port byte i = BLANK_PATTERN if (phase && BLINK_MASK[i]); otherwise DATA byte i.
- Writing DATA does not disturb `cnt` or phase.

## Timing
- Reset values:
  - DATA[b] = RESET_PATTERN;
  - BLINK_MASK = 0;
  - BLINK_PERIOD = BLINK_PERIOD_RST;
  - `cnt` = BLINK_PERIOD_RST-1 (0 if BLINK_PERIOD_RST is 0);
  - phase = 0.
  - Therefore `out_port` = RESET_PATTERN replicated, and `readdata` = 0 when not selected or unmapped.
- Write at edge N: the register and `out_port` reflect the new value after edge N, with one-cycle write latency.
- Period P≥1 written at edge N: phase toggles at edges N+P, N+2P, … P=1 toggles every cycle.
- Reset asserted mid-count: all state returns to reset values on the next edge. Reset overrides a simultaneous write.
- Clearing a mask bit while phase=1 unblanks that digit after the write edge.

## Configuration
- `QSYS_HEX_PIO_BLINK_EN` defined: the blink engine, BLINK_MASK, BLINK_PERIOD and STATUS are implemented as above.
- Not defined:
  - offsets 8, 9 and 10 read 0 and ignore writes;
  - there is no counter logic;
  - `out_port` equals the DATA registers directly.

## Test plan
- Reset, NUM_BANKS=2: `out_port`=64'h40404040_40404040. Reads of offsets 0, 1 → 32'h40404040; read of offset 5 → 0.
- Write offset 1 = 32'h12345678 with byteenable=4'b0101: DATA[1]=32'h40344078, and `out_port`[63:32] updates one cycle after the write edge.
- BLINK_MASK=32'h0000_0011, then BLINK_PERIOD=3 written at edge N:
  - digits 0 and 4 read BLANK_PATTERN after edges N+3 through N+5;
  - they restore DATA after edge N+6;
  - STATUS bit0 tracks this.
- Rewrite BLINK_PERIOD=3 while phase=1: phase clears after the write edge, and the next toggle is 3 edges later. Writing 0 stops blinking permanently.
- Assert `reset` for one cycle mid-blink with phase=1 and the DATA registers modified: everything returns to reset values after that edge, including a write presented on the same cycle.
- Build without `QSYS_HEX_PIO_BLINK_EN`: writes to offsets 8 and 9 have no effect, read back 0, and `out_port` never blanks.
